// File: rtl/wb_pkg.sv
// wb_pkg: widths, FSM state indices and default error data shared by the
// Wishbone slave decoder and its address-match sub-module.
package wb_pkg;

    localparam int ADR_W = 36;
    localparam int DAT_W = 32;
    localparam int N_SLV = 4;

    // Bit positions of the one-hot decoder states
    localparam int ST_IDLE_IX   = 0;
    localparam int ST_ACTIVE_IX = 1;
    localparam int ST_RESP_IX   = 2;
    localparam int ST_ERR_IX    = 3;
    localparam int N_ST         = 4;

    typedef enum logic [N_ST-1:0] {
        ST_IDLE   = N_ST'(1 << ST_IDLE_IX),
        ST_ACTIVE = N_ST'(1 << ST_ACTIVE_IX),
        ST_RESP   = N_ST'(1 << ST_RESP_IX),
        ST_ERR    = N_ST'(1 << ST_ERR_IX)
    } state_t;

    // Read data handed back when a cycle is terminated by the decoder itself
    localparam logic [DAT_W-1:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb_addr_match.sv
// wb_addr_match: combinational base/mask compare over all slaves. Overlapping
// windows resolve to the lowest slave index; none_o flags an unmapped address.
module wb_addr_match
    import wb_pkg::*;
#(
    parameter logic [N_SLV*ADR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADR_W-1:0] adr_i,
    output logic [N_SLV-1:0] hit_o,
    output logic             none_o
);

    // Scan from the highest index down so the lowest matching slave is kept
    always_comb begin
        // NOTE: every output gets a value before any branch, otherwise a
        // path that skips the assignment would infer a latch.
        hit_o  = '0;
        none_o = 1'b1;
        for (int n = N_SLV - 1; n >= 0; n--) begin
            if ((adr_i & SLV_MASK[n*ADR_W +: ADR_W]) == SLV_BASE[n*ADR_W +: ADR_W]) begin
                hit_o    = '0;
                hit_o[n] = 1'b1;
                none_o   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder: routes one Wishbone master onto four slave ports with
// registered strobes and a registered response. Unmapped addresses (and, when
// WB_DECODER_TIMEOUT_EN is defined, slaves that never ack) are terminated with
// a synthetic ack carrying ERR_DATA plus a bus_err_o pulse.
module wb_slave_decoder
    import wb_pkg::*;
#(
    parameter logic [N_SLV*ADR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLV*ADR_W-1:0] SLV_MASK = '0,
    parameter int unsigned            TIMEOUT  = 1024,
    parameter logic [DAT_W-1:0]       ERR_DATA = DEFAULT_ERR_DATA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADR_W-1:0]       s_adr_i,
    input  logic [DAT_W-1:0]       s_dat_i,
    input  logic [3:0]             s_sel_i,
    input  logic                   s_we_i,
    input  logic                   s_stb_i,
    input  logic                   s_cyc_i,
    output logic [DAT_W-1:0]       s_dat_o,
    output logic                   s_ack_o,
    output logic [ADR_W-1:0]       m_adr_o,
    output logic [DAT_W-1:0]       m_dat_o,
    output logic [3:0]             m_sel_o,
    output logic                   m_we_o,
    output logic [N_SLV-1:0]       m_cyc_o,
    output logic [N_SLV-1:0]       m_stb_o,
    input  logic [N_SLV*DAT_W-1:0] m_dat_i,
    input  logic [N_SLV-1:0]       m_ack_i,
    output logic                   bus_err_o,
    output logic [ADR_W-1:0]       err_adr_o
);

    // Reject an out-of-range timeout at elaboration
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("wb_slave_decoder: TIMEOUT must be within 2..65535");
    end

    state_t            state_q, state_d;
    logic [N_SLV-1:0]  stb_q, stb_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DAT_W-1:0]  rdat_q, rdat_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [DAT_W-1:0]  wdat_q, wdat_d;
    logic [3:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [ADR_W-1:0]  err_adr_q, err_adr_d;

    logic [N_SLV-1:0]  hit;
    logic              hit_none;
    logic              slv_ack;
    logic [DAT_W-1:0]  slv_rdata;

`ifdef WB_DECODER_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    wb_addr_match #(
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .adr_i  (s_adr_i),
        .hit_o  (hit),
        .none_o (hit_none)
    );

    // Only the selected port's ack and read lane are visible; the rest are ignored
    always_comb begin
        slv_rdata = '0;
        for (int n = 0; n < N_SLV; n++) begin
            if (stb_q[n]) begin
                slv_rdata = slv_rdata | m_dat_i[n*DAT_W +: DAT_W];
            end
        end
    end

    assign slv_ack = |(m_ack_i & stb_q);

    // Next-state and registered-output decisions for the cycle FSM
    always_comb begin
        state_d   = state_q;
        stb_d     = stb_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdat_d    = rdat_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        err_adr_d = err_adr_q;
`ifdef WB_DECODER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    adr_d  = s_adr_i;
                    wdat_d = s_dat_i;
                    sel_d  = s_sel_i;
                    we_d   = s_we_i;
                    if (hit_none) begin
                        // Unmapped: answer straight away; a write is simply dropped
                        state_d   = ST_ERR;
                        ack_d     = 1'b1;
                        err_d     = 1'b1;
                        rdat_d    = ERR_DATA;
                        err_adr_d = s_adr_i;
                    end else begin
                        state_d = ST_ACTIVE;
                        stb_d   = hit;
`ifdef WB_DECODER_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ST_ACTIVE: begin
                if (!s_cyc_i) begin
                    // Master walked away: release the slave, owe no ack
                    state_d = ST_IDLE;
                    stb_d   = '0;
                end else if (slv_ack) begin
                    // A slave ack beats a timeout landing on the same edge
                    state_d = ST_RESP;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    rdat_d  = slv_rdata;
                end
`ifdef WB_DECODER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_ERR;
                    stb_d     = '0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    rdat_d    = ERR_DATA;
                    err_adr_d = adr_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP, ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = '0;
            end
        endcase
    end

    // State and output registers; reset drops every strobe and the ack at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            stb_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            err_adr_q <= '0;
`ifdef WB_DECODER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            state_q   <= state_d;
            stb_q     <= stb_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            err_adr_q <= err_adr_d;
`ifdef WB_DECODER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign s_dat_o   = rdat_q;
    assign s_ack_o   = ack_q;
    assign m_adr_o   = adr_q;
    assign m_dat_o   = wdat_q;
    assign m_sel_o   = sel_q;
    assign m_we_o    = we_q;
    assign m_cyc_o   = stb_q;
    assign m_stb_o   = stb_q;
    assign bus_err_o = err_q;
    assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_wb_slave_decoder.sv
// tb_wb_slave_decoder: directed plus random transactions against a
// transaction-level timeline model; every cycle is compared.
module tb_wb_slave_decoder;

    localparam int TO = 8;
    localparam logic [143:0] BASE = {36'h0_0000_0000, 36'h2_0000_0000,
                                     36'h1_0000_0000, 36'h0_0000_0000};
    localparam logic [143:0] MASK = {36'hF_0000_0000, 36'hF_0000_0000,
                                     36'hF_0000_0000, 36'hF_FFFF_0000};
    localparam logic [31:0] ERRD  = 32'hDEADBEEF;
    localparam int          NEVER = 32'h3FFF_FFFF;
`ifdef WB_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [35:0]  s_adr_i;
    logic [31:0]  s_dat_i;
    logic [3:0]   s_sel_i;
    logic         s_we_i, s_stb_i, s_cyc_i;
    logic [31:0]  s_dat_o;
    logic         s_ack_o;
    logic [35:0]  m_adr_o;
    logic [31:0]  m_dat_o;
    logic [3:0]   m_sel_o;
    logic         m_we_o;
    logic [3:0]   m_cyc_o, m_stb_o;
    logic [127:0] m_dat_i;
    logic [3:0]   m_ack_i;
    logic         bus_err_o;
    logic [35:0]  err_adr_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    bit cmp_en   = 1'b0;

    // Slave behaviour
    int          slv_wait  [4];
    bit          slv_hang  [4];
    logic [31:0] slv_rdata [4];
    int          wcnt      [4];
    logic [3:0]  ack_noise;
    logic [31:0] noise_dat [4];

    // Transaction timeline model
    bit          t_valid;
    int          t_c0, t_stb_end, t_ack_c, t_tgt;
    bit          t_err;
    logic [31:0] t_rdat, t_wdat;
    logic [35:0] t_adr;
    logic [3:0]  t_sel;
    bit          t_we;
    logic [35:0] err_adr_model;

    wb_slave_decoder #(
        .SLV_BASE (BASE),
        .SLV_MASK (MASK),
        .TIMEOUT  (TO),
        .ERR_DATA (ERRD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_adr_i   (s_adr_i),
        .s_dat_i   (s_dat_i),
        .s_sel_i   (s_sel_i),
        .s_we_i    (s_we_i),
        .s_stb_i   (s_stb_i),
        .s_cyc_i   (s_cyc_i),
        .s_dat_o   (s_dat_o),
        .s_ack_o   (s_ack_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_sel_o   (m_sel_o),
        .m_we_o    (m_we_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack_i),
        .bus_err_o (bus_err_o),
        .err_adr_o (err_adr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [35:0] a);
        for (int n = 0; n < 4; n++) begin
            if ((a & MASK[n*36 +: 36]) == BASE[n*36 +: 36]) return n;
        end
        return -1;
    endfunction

    // Slaves: ack once strobed for slv_wait cycles; unselected ports chatter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 4; n++) wcnt[n] <= 0;
        end else begin
            for (int n = 0; n < 4; n++) wcnt[n] <= m_stb_o[n] ? wcnt[n] + 1 : 0;
        end
    end

    always @(negedge clk) begin
        ack_noise <= 4'($urandom);
        for (int n = 0; n < 4; n++) noise_dat[n] <= $urandom;
    end

    always_comb begin
        m_ack_i = '0;
        m_dat_i = '0;
        for (int n = 0; n < 4; n++) begin
            m_ack_i[n] = m_stb_o[n] ? (!slv_hang[n] && wcnt[n] >= slv_wait[n]) : ack_noise[n];
            m_dat_i[n*32 +: 32] = m_stb_o[n] ? slv_rdata[n] : noise_dat[n];
        end
    end

    // Per-cycle comparison against the timeline model
    int          e;
    logic [3:0]  exp_stb;
    bit          exp_ack;
    logic [35:0] exp_err_adr;
    always @(posedge clk) begin
        #1;
        if (cmp_en && rst_n) begin
            e           = cyc_n;
            exp_stb     = '0;
            exp_ack     = 1'b0;
            exp_err_adr = err_adr_model;
            if (t_valid) begin
                if (t_tgt >= 0 && e >= t_c0 && e < t_stb_end) exp_stb = 4'(1 << t_tgt);
                exp_ack = (t_ack_c >= 0) && (e == t_ack_c);
                if (t_err && t_ack_c >= 0 && e >= t_ack_c) exp_err_adr = t_adr;
            end
            check("m_stb_o", m_stb_o, exp_stb);
            check("m_cyc_o", m_cyc_o, exp_stb);
            check("s_ack_o", s_ack_o, exp_ack);
            check("bus_err_o", bus_err_o, exp_ack && t_err);
            check("err_adr_o", err_adr_o, exp_err_adr);
            if (exp_ack) check("s_dat_o", s_dat_o, t_rdat);
            if (exp_stb != 0) begin
                check("m_adr_o", m_adr_o, t_adr);
                check("m_dat_o", m_dat_o, t_wdat);
                check("m_sel_o", m_sel_o, t_sel);
                check("m_we_o", m_we_o, t_we);
            end
        end
    end

    // Called at a falling edge: program the slave, predict the timeline, drive the request
    task automatic start_txn(input logic [35:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                             input bit we, input int w, input bit h, input logic [31:0] rd);
        int tgt;
        tgt = decode(adr);
        if (tgt >= 0) begin
            slv_wait[tgt]  = w;
            slv_hang[tgt]  = h;
            slv_rdata[tgt] = rd;
        end
        if (t_valid && t_err) err_adr_model = t_adr;
        t_c0 = cyc_n + 1;
        t_tgt = tgt; t_adr = adr; t_wdat = dat; t_sel = sel; t_we = we;
        t_err = 1'b0; t_ack_c = t_c0 + 1 + w; t_stb_end = t_ack_c; t_rdat = rd;
        if (tgt < 0) begin
            t_err = 1'b1; t_ack_c = t_c0; t_stb_end = t_c0; t_rdat = ERRD;
        end else if (TO_EN && (h || w + 1 > TO)) begin
            t_err = 1'b1; t_ack_c = t_c0 + TO; t_stb_end = t_ack_c; t_rdat = ERRD;
        end else if (h) begin
            t_ack_c = -1; t_stb_end = NEVER;
        end
        t_valid = 1'b1;
        s_adr_i = adr; s_dat_i = dat; s_sel_i = sel; s_we_i = we;
        s_cyc_i = 1'b1; s_stb_i = 1'b1;
    endtask

    // Wait (bounded) for the ack, or abandon after ab cycles when ab > 0
    task automatic wait_ack(input int budget, input int ab, output int lat, output logic [3:0] stbs,
                            output logic [31:0] rdat, output logic [31:0] mdat, output bit errs);
        lat = -1; stbs = '0; rdat = '0; mdat = '0; errs = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            stbs = stbs | m_stb_o;
            errs = errs | bus_err_o;
            if (m_stb_o != 0) mdat = m_dat_o;
            if (s_ack_o) begin
                lat  = cyc_n - t_c0 + 1;
                rdat = s_dat_o;
                break;
            end
            if (ab > 0 && i + 1 == ab) begin
                t_stb_end = cyc_n + 1;
                break;
            end
        end
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        @(negedge clk);
    endtask

    int          lat, w, r;
    bit          h;
    logic [3:0]  stbs;
    logic [31:0] rdat, mdat;
    bit          errs;
    logic [35:0] adr;

    initial begin
        rst_n = 1'b1;
        s_adr_i = '0; s_dat_i = '0; s_sel_i = '0; s_we_i = 1'b0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
        t_valid = 1'b0; t_err = 1'b0; t_adr = '0; err_adr_model = '0;
        for (int n = 0; n < 4; n++) begin
            slv_wait[n] = 0; slv_hang[n] = 1'b0; slv_rdata[n] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ack", s_ack_o, 0);
        check("rst_m_stb", m_stb_o, 0);
        check("rst_bus_err", bus_err_o, 0);
        check("rst_s_dat", s_dat_o, 0);
        check("rst_err_adr", err_adr_o, 0);
        check("rst_m_adr", m_adr_o, 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Zero-wait write to slave 1
        start_txn(36'h1_0000_0010, 32'h12345678, 4'hF, 1'b1, 0, 1'b0, 32'h0);
        wait_ack(50, 0, lat, stbs, rdat, mdat, errs);
        check("wr1_stb", stbs, 4'b0010);
        check("wr1_mdat", mdat, 32'h12345678);
        check("wr1_lat", lat, 2);

        // Slave 2 read with 5 wait cycles
        start_txn(36'h2_0000_0004, 32'h0, 4'hF, 1'b0, 5, 1'b0, 32'hCAFEF00D);
        wait_ack(50, 0, lat, stbs, rdat, mdat, errs);
        check("rd2_dat", rdat, 32'hCAFEF00D);
        check("rd2_lat", lat, 7);

        // Unmapped read
        start_txn(36'hF_FFFF_FFFF, 32'h0, 4'hF, 1'b0, 0, 1'b0, 32'h0);
        wait_ack(50, 0, lat, stbs, rdat, mdat, errs);
        check("unm_lat", lat, 1);
        check("unm_dat", rdat, 32'hDEADBEEF);
        check("unm_err", errs, 1);
        check("unm_stb", stbs, 0);
        check("unm_err_adr", err_adr_o, 36'hF_FFFF_FFFF);

        // Slave 3 never acks
`ifdef WB_DECODER_TIMEOUT_EN
        start_txn(36'h0_1234_0000, 32'h0, 4'hF, 1'b0, 0, 1'b1, 32'h0);
        wait_ack(50, 0, lat, stbs, rdat, mdat, errs);
        check("to_lat", lat, 9);
        check("to_dat", rdat, 32'hDEADBEEF);
        check("to_err", errs, 1);
        check("to_stb", stbs, 4'b1000);
        check("to_stb_clr", m_stb_o, 0);
        check("to_err_adr", err_adr_o, 36'h0_1234_0000);
        // Ack on the timeout edge wins; one cycle later it loses
        start_txn(36'h1_0000_0080, 32'h0, 4'hF, 1'b0, TO - 1, 1'b0, 32'h600DF00D);
        wait_ack(50, 0, lat, stbs, rdat, mdat, errs);
        check("race_lat", lat, 9);
        check("race_dat", rdat, 32'h600DF00D);
        check("race_err", errs, 0);
        start_txn(36'h1_0000_0084, 32'h0, 4'hF, 1'b0, TO, 1'b0, 32'h600DF00D);
        wait_ack(50, 0, lat, stbs, rdat, mdat, errs);
        check("late_lat", lat, 9);
        check("late_dat", rdat, 32'hDEADBEEF);
`else
        start_txn(36'h0_1234_0000, 32'h0, 4'hF, 1'b0, 0, 1'b1, 32'h0);
        wait_ack(1010, 1000, lat, stbs, rdat, mdat, errs);
        check("hang_no_ack", lat, -1);
        check("hang_stb", stbs, 4'b1000);
        check("hang_stb_clr", m_stb_o, 0);
`endif
        slv_hang[3] = 1'b0;

        // Overlapping windows: slave 0 wins over slave 3
        start_txn(36'h0_0000_0040, 32'hA5A5_5A5A, 4'h3, 1'b1, 1, 1'b0, 32'h0);
        wait_ack(50, 0, lat, stbs, rdat, mdat, errs);
        check("ovl_stb", stbs, 4'b0001);
        check("ovl_lat", lat, 3);

        // Master abandons a slow slave
        start_txn(36'h0_0100_0000, 32'h0, 4'hF, 1'b0, 30, 1'b0, 32'h0);
        wait_ack(50, 3, lat, stbs, rdat, mdat, errs);
        check("abn_no_ack", lat, -1);
        check("abn_stb", stbs, 4'b1000);
        check("abn_err", errs, 0);
        check("abn_stb_clr", m_stb_o, 0);

        // Reset in the middle of an ACTIVE cycle
        start_txn(36'h2_0000_0100, 32'h0, 4'hF, 1'b0, 30, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0; t_valid = 1'b0; err_adr_model = '0;
        s_cyc_i = 1'b0; s_stb_i = 1'b0;
        #1;
        check("arst_m_stb", m_stb_o, 0);
        check("arst_m_cyc", m_cyc_o, 0);
        check("arst_s_ack", s_ack_o, 0);
        check("arst_err_adr", err_adr_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_txn(36'h1_0000_0020, 32'h0, 4'hF, 1'b0, 0, 1'b0, 32'h1357_9BDF);
        wait_ack(50, 0, lat, stbs, rdat, mdat, errs);
        check("post_rst_lat", lat, 2);
        check("post_rst_dat", rdat, 32'h1357_9BDF);

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 4);
            case (r)
                0:       adr = {20'h0, 16'($urandom)};
                1:       adr = {4'h1, 32'($urandom)};
                2:       adr = {4'h2, 32'($urandom)};
                3:       adr = {4'h0, 16'($urandom_range(1, 65535)), 16'($urandom)};
                default: adr = {4'($urandom_range(3, 15)), 32'($urandom)};
            endcase
            w = TO_EN ? $urandom_range(0, TO + 1) : $urandom_range(0, 6);
            h = TO_EN && ($urandom_range(0, 9) == 0);
            start_txn(adr, $urandom, 4'($urandom), 1'($urandom), w, h, $urandom);
            wait_ack(TO + 20, 0, lat, stbs, rdat, mdat, errs);
            check("rnd_lat", lat, t_ack_c - t_c0 + 1);
            slv_hang[0] = 1'b0; slv_hang[1] = 1'b0; slv_hang[2] = 1'b0; slv_hang[3] = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_slave_decoder.md
# wb_slave_decoder

Wishbone interconnect stage sitting directly downstream of the LIMB-to-Wishbone master: decodes its 36-bit address onto one of four slave ports, forwards the cycle with registered strobes, and returns the response. Unmapped addresses and hung slaves are terminated with a synthetic ack carrying `ERR_DATA`. The upstream master has no error input, so no cycle can stall forever.

## Interface
- `SLV_BASE`, default all zeros (144 bits). Four 36-bit base addresses; slave n occupies `[36n+:36]`.
- `SLV_MASK`, default all zeros (144 bits). Four 36-bit compare masks. Slave n hits when `(adr & mask_n) == base_n`.
- `TIMEOUT`, default 1024. Number of ACTIVE cycles before the cycle is aborted; legal range 2..65535.
- `ERR_DATA`, default `32'hDEADBEEF`. Read data returned on an error termination.

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `s_adr_i`  in  36  master address
- `s_dat_i`  in  32  master write data
- `s_sel_i`  in  4  byte selects
- `s_we_i`, `s_stb_i`, `s_cyc_i`  in  1 each  master controls
- `s_dat_o`  out  32  read data to master (registered)
- `s_ack_o`  out  1  cycle termination (registered)
- `m_adr_o`  out  36  shared slave address (registered)
- `m_dat_o`  out  32  shared slave write data (registered)
- `m_sel_o`  out  4  shared byte selects (registered)
- `m_we_o`  out  1  shared write enable (registered)
- `m_cyc_o`, `m_stb_o`  out  4  one-hot per-slave controls
- `m_dat_i`  in  128  slave read data; slave n at `[32n+:32]`
- `m_ack_i`  in  4  per-slave ack
- `bus_err_o`  out  1  one-cycle pulse on every error termination
- `err_adr_o`  out  36  address of the most recent error termination

## Operation
- States: IDLE, ACTIVE, RESP, ERR. Encoding is one-hot.
- **IDLE**
  - Requires `s_cyc_i && s_stb_i` to start a cycle.
  - On a start, register `adr`/`dat`/`sel`/`we` onto the `m_*` buses and compute the hit vector.
  - Overlapping hits resolve to the lowest index.
  - If any slave hits, go to ACTIVE with `m_cyc_o[n]`/`m_stb_o[n]` set. If none hits, go to ERR.
- **ACTIVE**
  - The timeout counter increments each cycle.
  - `m_ack_i[n]` → capture `m_dat_i[32n+:32]` into `s_dat_o`, clear `m_cyc_o`/`m_stb_o`, go to RESP.
  - Counter == `TIMEOUT-1` with no ack → clear strobes, go to ERR.
  - An ack in the same cycle as the timeout wins.
  - Acks on non-selected ports are ignored.
- **RESP**: `s_ack_o=1` for exactly one cycle, then go to IDLE.
- **ERR**
  - `s_ack_o=1`, `s_dat_o=ERR_DATA`, `bus_err_o=1`, and `err_adr_o` is loaded from the registered address. This holds for one cycle, then go to IDLE.
  - A write that ends in ERR is dropped. It is still acked.
- **Master abandon**: `s_cyc_i` low while in ACTIVE → clear strobes and go to IDLE with no ack. `s_cyc_i` low while in RESP or ERR → the ack is still issued and is harmless.
- **Reset values**: state IDLE; `s_ack_o`, `m_cyc_o`, `m_stb_o`, `m_we_o`, `bus_err_o` are 0; `s_dat_o`, `m_adr_o`, `m_dat_o`, `m_sel_o`, `err_adr_o` are 0; counter 0.
- **Reset asserted mid-cycle**: all strobes and the ack drop immediately. No response is owed to the master.

## Timing
- `s_stb_i` is sampled at edge E0.
- Mapped slave: `m_stb_o` is high after E0. A zero-wait slave acks before E1. `s_ack_o` is high between E1 and E2. Minimum latency is 2 cycles.
- Unmapped address: `s_ack_o` is high between E0 and E1. Latency is 1 cycle.
- Timeout: `s_ack_o` asserts `TIMEOUT+1` cycles after E0.
- `s_ack_o` never stays high for two consecutive cycles. The master is expected to drop `stb` on the edge where it samples ack.
- The counter width is the minimal width that holds `TIMEOUT`. The counter clears on entry to ACTIVE and never wraps.

## Configuration
- `WB_DECODER_TIMEOUT_EN`
  - **Defined**: the timeout counter and the ACTIVE→ERR path exist.
  - **Undefined**: no counter; ACTIVE waits indefinitely for the ack. Unmapped-address ERR, `bus_err_o` and `err_adr_o` remain.

## Structure
- Shared package `wb_pkg` holds:
  - the address width (36) and data width (32);
  - the state index localparams;
  - the default `ERR_DATA`.
- Sub-module `wb_addr_match`: purely combinational base/mask compare over 4 slaves with lowest-index priority. It outputs a one-hot hit vector and a `none` flag.

## Test plan
- Slave 1 at base `36'h1_0000_0000` mask `36'hF_0000_0000`, zero-wait. Write `adr=36'h1_0000_0010`, `dat=32'h12345678`. Expect: only `m_stb_o[1]` pulses with `m_dat_o=32'h12345678`; `s_ack_o` arrives 2 cycles after stb.
- Read from slave 2, which returns `32'hCAFEF00D` after 5 wait cycles. Expect `s_dat_o=32'hCAFEF00D` with `s_ack_o` on cycle 7.
- Read `adr=36'hF_FFFF_FFFF` (unmapped). Expect:
  - `s_ack_o` after 1 cycle;
  - `s_dat_o=32'hDEADBEEF`;
  - `bus_err_o` pulse;
  - `err_adr_o=36'hF_FFFF_FFFF`;
  - no `m_stb_o` activity.
- `TIMEOUT=8`, slave never acks. Expect ERR ack 9 cycles after stb and `m_stb_o` cleared. With the macro undefined, expect no ack after 1000 cycles.
- Overlap: slaves 0 and 3 both match. Expect only port 0 to be strobed.
- Drop `rst_n` during ACTIVE. Expect all `m_*` strobes 0 asynchronously, and the next cycle after release to decode normally.
